// File: rtl/dbus_resp.sv
// Data-bus responder for the execute-stage memory port: data RAM, 32-bit timer with IRQ, GPIO.
// Reads are combinational and writes commit at the next core_clk edge; the port is always ready.
module dbus_resp #(
  parameter int RAM_AW = 12,
  parameter int GPIO_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_we_i,
  input  logic [31:0]       mem_raddr_i,
  input  logic [31:0]       mem_waddr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic [31:0]       mem_rdata_o,
  input  logic [GPIO_W-1:0] gpio_i,
  output logic [GPIO_W-1:0] gpio_o,
  output logic              timer_irq_o
);

  localparam logic [3:0] REGION_RAM   = 4'h0;
  localparam logic [3:0] REGION_TIMER = 4'h1;
  localparam logic [3:0] REGION_GPIO  = 4'h2;

  localparam logic [1:0] TMR_CTRL   = 2'd0;
  localparam logic [1:0] TMR_COUNT  = 2'd1;
  localparam logic [1:0] TMR_CMP    = 2'd2;
  localparam logic [1:0] TMR_STATUS = 2'd3;

  localparam int RAM_DEPTH = 2 ** RAM_AW;

  logic [31:0] ram [RAM_DEPTH];

  logic        ctrl_irq_en;
  logic        ctrl_auto_reload;
  logic        ctrl_en;
  logic [31:0] count;
  logic [31:0] cmp;
  logic        match;

  logic [GPIO_W-1:0] gpio_out;
  logic [GPIO_W-1:0] gpio_sync1;
  logic [GPIO_W-1:0] gpio_sync2;

  logic [RAM_AW-1:0] ram_ridx;
  logic [RAM_AW-1:0] ram_widx;
  logic              wr_ram;
  logic              wr_timer;
  logic              wr_gpio;
  logic              ctrl_wr;
  logic              count_wr;
  logic              cmp_wr;
  logic              status_wr;
  logic              gpio_out_wr;
  logic              match_evt;
  logic [31:0]       gpio_out_ext;
  logic [31:0]       gpio_in_ext;
  logic              unused_bits;

  assign ram_ridx = mem_raddr_i[RAM_AW+1:2];
  assign ram_widx = mem_waddr_i[RAM_AW+1:2];

  // Write decode: only one target can be selected per cycle.
  assign wr_ram      = mem_we_i && (mem_waddr_i[31:28] == REGION_RAM);
  assign wr_timer    = mem_we_i && (mem_waddr_i[31:28] == REGION_TIMER);
  assign wr_gpio     = mem_we_i && (mem_waddr_i[31:28] == REGION_GPIO);
  assign ctrl_wr     = wr_timer && (mem_waddr_i[3:2] == TMR_CTRL);
  assign count_wr    = wr_timer && (mem_waddr_i[3:2] == TMR_COUNT);
  assign cmp_wr      = wr_timer && (mem_waddr_i[3:2] == TMR_CMP);
  assign status_wr   = wr_timer && (mem_waddr_i[3:2] == TMR_STATUS);
  assign gpio_out_wr = wr_gpio && !mem_waddr_i[2];

  // A software COUNT load pre-empts the compare, so it also suppresses the match event.
  assign match_evt = ctrl_en && (count == cmp) && !count_wr;

  always_ff @(posedge clk) begin
    if (wr_ram) begin
      ram[ram_widx] <= mem_wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_irq_en      <= 1'b0;
      ctrl_auto_reload <= 1'b0;
      ctrl_en          <= 1'b0;
      count            <= '0;
      cmp              <= '0;
      match            <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        ctrl_irq_en      <= mem_wdata_i[2];
        ctrl_auto_reload <= mem_wdata_i[1];
        ctrl_en          <= mem_wdata_i[0];
      end
      if (cmp_wr) begin
        cmp <= mem_wdata_i;
      end
      if (count_wr) begin
        count <= mem_wdata_i;
      end else if (match_evt) begin
        count <= ctrl_auto_reload ? 32'd0 : count + 32'd1;
      end else if (ctrl_en) begin
        count <= count + 32'd1;
      end
      // A new match outranks a same-cycle W1C.
      if (match_evt) begin
        match <= 1'b1;
      end else if (status_wr && mem_wdata_i[0]) begin
        match <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_out   <= '0;
      gpio_sync1 <= '0;
      gpio_sync2 <= '0;
    end else begin
      if (gpio_out_wr) begin
        gpio_out <= mem_wdata_i[GPIO_W-1:0];
      end
      gpio_sync1 <= gpio_i;
      gpio_sync2 <= gpio_sync1;
    end
  end

  always_comb begin
    gpio_out_ext = '0;
    gpio_in_ext  = '0;
    gpio_out_ext[GPIO_W-1:0] = gpio_out;
    gpio_in_ext[GPIO_W-1:0]  = gpio_sync2;
  end

  always_comb begin
    mem_rdata_o = '0;
    case (mem_raddr_i[31:28])
      REGION_RAM: mem_rdata_o = ram[ram_ridx];
      REGION_TIMER: begin
        case (mem_raddr_i[3:2])
          TMR_CTRL:   mem_rdata_o = {29'd0, ctrl_irq_en, ctrl_auto_reload, ctrl_en};
          TMR_COUNT:  mem_rdata_o = count;
          TMR_CMP:    mem_rdata_o = cmp;
          TMR_STATUS: mem_rdata_o = {31'd0, match};
          default:    mem_rdata_o = '0;
        endcase
      end
      REGION_GPIO: mem_rdata_o = mem_raddr_i[2] ? gpio_in_ext : gpio_out_ext;
      default:     mem_rdata_o = '0;
    endcase
  end

  assign gpio_o      = gpio_out;
  assign timer_irq_o = match && ctrl_irq_en;

  // Byte-offset and aliased upper address bits are don't-cares by design.
  assign unused_bits = ^{mem_raddr_i, mem_waddr_i, mem_wdata_i};

endmodule
